plot_arbiter: RTL

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_pkg.sv | 66 ++++++
 rtl/rect_scanner.sv | 74 +++++++
 rtl/plot_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/plot_pkg.sv
// Shared definitions for the plot arbiter: FSM states, letter geometry and
// the hangman part table.
package plot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_LETTER = 1'b0,
        GRANT_MISS   = 1'b1
    } grant_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [3:0] w;
        logic [3:0] h;
    } rect_t;

    localparam logic [7:0] LETTER_X0     = 8'd42;
    localparam logic [7:0] LETTER_PITCH  = 8'd5;
    localparam logic [6:0] LETTER_Y0     = 7'd100;
    localparam logic [3:0] LETTER_W      = 4'd4;
    localparam logic [3:0] LETTER_H      = 4'd6;
    localparam logic [2:0] LETTER_COLOUR = 3'b010;
    localparam logic [2:0] HANG_COLOUR   = 3'b111;

    // Indexed by wrong-guess count: head, body, arms, legs.
    localparam rect_t HANG_PARTS [1:6] = '{
        '{x0: 8'd20, y0: 7'd20, w: 4'd5, h: 4'd5},
        '{x0: 8'd22, y0: 7'd25, w: 4'd1, h: 4'd12},
        '{x0: 8'd18, y0: 7'd28, w: 4'd4, h: 4'd1},
        '{x0: 8'd23, y0: 7'd28, w: 4'd4, h: 4'd1},
        '{x0: 8'd20, y0: 7'd37, w: 4'd2, h: 4'd6},
        '{x0: 8'd23, y0: 7'd37, w: 4'd2, h: 4'd6}
    };

    function automatic logic letter_valid(input logic [2:0] idx);
        return (idx >= 3'd1) && (idx <= 3'd5);
    endfunction

    function automatic logic miss_valid(input logic [2:0] count);
        return (count >= 3'd1) && (count <= 3'd6);
    endfunction

    function automatic rect_t letter_rect(input logic [2:0] idx);
        rect_t r;
        r.x0 = LETTER_X0 + LETTER_PITCH * ({5'b0, idx} - 8'd1);
        r.y0 = LETTER_Y0;
        r.w  = LETTER_W;
        r.h  = LETTER_H;
        return r;
    endfunction

    function automatic rect_t hang_part(input logic [2:0] count);
        rect_t r;
        r = '0;
        if (miss_valid(count))
            r = HANG_PARTS[count];
        return r;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster-scans a latched rectangle one pixel per cycle, column fastest,
// presenting registered x/y/plot and flagging the final pixel.
module rect_scanner
    import plot_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [3:0] w,
    input  logic [3:0] h,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       last_pixel
);

    logic [7:0] ox;
    logic [6:0] oy;
    logic [3:0] rw;
    logic [3:0] rh;
    logic [3:0] cx;
    logic [3:0] cy;
    logic [3:0] cx_n;
    logic [3:0] cy_n;
    logic       row_end;

    always_comb begin
        cx_n       = cx + 4'd1;
        cy_n       = cy + 4'd1;
        row_end    = (cx == rw - 4'd1);
        last_pixel = plot && row_end && (cy == rh - 4'd1);
    end

    // cx/cy always name the pixel currently on x/y, so the first pixel
    // is presented in the same edge that accepts start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ox   <= '0;
            oy   <= '0;
            rw   <= '0;
            rh   <= '0;
            cx   <= '0;
            cy   <= '0;
            x    <= '0;
            y    <= '0;
            plot <= 1'b0;
        end else if (start) begin
            ox   <= x0;
            oy   <= y0;
            rw   <= w;
            rh   <= h;
            cx   <= '0;
            cy   <= '0;
            x    <= x0;
            y    <= y0;
            plot <= 1'b1;
        end else if (plot) begin
            if (last_pixel) begin
                plot <= 1'b0;
            end else if (row_end) begin
                cx <= '0;
                cy <= cy_n;
                x  <= ox;
                y  <= oy + {3'b0, cy_n};
            end else begin
                cx <= cx_n;
                x  <= ox + {4'b0, cx_n};
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter between letter-unmask and hangman-part draw requests,
// driving the VGA pixel interface through a rectangle scanner.
module plot_arbiter
    import plot_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       letter_req,
    input  logic [2:0] letter_idx,
    input  logic       miss_req,
    input  logic [2:0] miss_count,
    output logic       letter_ack,
    output logic       miss_ack,
    output logic       err,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    state_t state;
    state_t next_state;
    grant_t last_grant;
    grant_t cur_grant;
    grant_t sel_grant;

    logic   grant;
    logic   sel_valid;
    rect_t  sel_rect;
    logic   start;
    logic   ack_fire;
    grant_t ack_grant;
    logic   err_fire;
    logic   last_pixel;

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        sel_grant  = GRANT_LETTER;
        sel_valid  = 1'b0;
        sel_rect   = '0;
        start      = 1'b0;
        ack_fire   = 1'b0;
        ack_grant  = cur_grant;
        err_fire   = 1'b0;

        case (state)
            IDLE: begin
                if (letter_req || miss_req) begin
                    grant = 1'b1;
                    if (miss_req && (!letter_req || last_grant == GRANT_LETTER))
                        sel_grant = GRANT_MISS;
                    if (sel_grant == GRANT_MISS) begin
                        sel_valid = miss_valid(miss_count);
                        sel_rect  = hang_part(miss_count);
                    end else begin
                        sel_valid = letter_valid(letter_idx);
                        sel_rect  = letter_rect(letter_idx);
                    end
                    start = sel_valid;
                    if (sel_valid) begin
                        next_state = DRAW;
                    end else begin
                        next_state = ACK;
                        ack_fire   = 1'b1;
                        ack_grant  = sel_grant;
                        err_fire   = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (last_pixel) begin
                    next_state = ACK;
                    ack_fire   = 1'b1;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= GRANT_MISS;
            cur_grant  <= GRANT_LETTER;
            colour     <= '0;
            letter_ack <= 1'b0;
            miss_ack   <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != IDLE);
            letter_ack <= ack_fire && (ack_grant == GRANT_LETTER);
            miss_ack   <= ack_fire && (ack_grant == GRANT_MISS);
            err        <= err_fire;
            if (grant) begin
                last_grant <= sel_grant;
                cur_grant  <= sel_grant;
                if (sel_valid)
                    colour <= (sel_grant == GRANT_MISS) ? HANG_COLOUR : LETTER_COLOUR;
            end
        end
    end

    rect_scanner u_scanner (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x0         (sel_rect.x0),
        .y0         (sel_rect.y0),
        .w          (sel_rect.w),
        .h          (sel_rect.h),
        .x          (x),
        .y          (y),
        .plot       (plot),
        .last_pixel (last_pixel)
    );

endmodule
